// File: rtl/lab1_pkg.sv
// lab1_pkg: shared debounce FSM state encoding and calculator opcodes.
package lab1_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } db_state_t;

    typedef enum logic [1:0] {
        PUSH = 2'b00,
        ADD  = 2'b01,
        MULT = 2'b10,
        SEND = 2'b11
    } opcode_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stable-count press/release filter.
module btn_debounce
    import lab1_pkg::*;
#(
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic accept
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync;
    logic             btn_s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign btn_s   = sync[1];
    assign cnt_inc = (cnt == LAST) ? cnt : cnt + CNT_W'(1);
    // accept fires on the edge that moves PRESS_DB into HELD, so the parent can capture in step
    assign accept  = (state == PRESS_DB) && btn_s && (cnt_inc == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= accept;
            case (state)
                IDLE: if (btn_s) begin
                    state <= PRESS_DB;
                    cnt   <= '0;
                end
                PRESS_DB: if (!btn_s) state <= IDLE;
                else begin
                    cnt <= cnt_inc;
                    if (cnt_inc == LAST) begin
                        state <= HELD;
                        level <= 1'b1;
                    end
                end
                HELD: if (!btn_s) begin
                    state <= REL_DB;
                    cnt   <= '0;
                end
                REL_DB: if (btn_s) state <= HELD;
                else begin
                    cnt <= cnt_inc;
                    if (cnt_inc == LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/inst_capture.sv
// inst_capture: debounces btnS and latches synchronized sw as one instruction per press.
module inst_capture
    import lab1_pkg::*;
#(
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic        btnS,
    output logic        inst_vld,
    output logic [7:0]  inst_wd,
    output logic [15:0] inst_cnt,
    output logic        btn_busy
);

    logic [7:0] sw_m;
    logic [7:0] sw_s;
    logic       accept;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btnS),
        .level (btn_busy),
        .rise  (inst_vld),
        .accept(accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m     <= '0;
            sw_s     <= '0;
            inst_wd  <= '0;
            inst_cnt <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            if (accept) begin
                inst_wd  <= sw_s;
                inst_cnt <= inst_cnt + 16'd1;
            end
        end
    end

endmodule
